// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and helpers for the 4x4 hex keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // One-cold drive with row 0 pulled low.
    localparam logic [3:0] ROWS_RESET = 4'b1110;

    // Hex code for each key, indexed [row][col].
    localparam logic [3:0] KEYMAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // One-cold row drive pattern for a row index.
    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Number of active-low column lines.
    function automatic logic [2:0] count_lows(input logic [3:0] c);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!c[i]) n = n + 3'd1;
        end
        return n;
    endfunction

    // Index of a low column line; only meaningful when exactly one is low.
    function automatic logic [1:0] low_index(input logic [3:0] c);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!c[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running divider emitting a one-clk tick every 2^SCAN_DIV_W clocks.
// Shared with the display driver's digit multiplexer.
module scan_tick_gen #(
    parameter int SCAN_DIV_W = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    logic [SCAN_DIV_W-1:0] r_div;

    // Divider counts up and wraps from all-ones back to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + SCAN_DIV_W'(1);
        end
    end

    assign o_tick = (r_div == '1);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low hex keypad, debounces presses and
// shifts each accepted digit into a 16-bit register for the display driver.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W     = 16,
`ifdef KEYPAD_AUTOREPEAT_EN
    parameter int REPEAT_SCANS   = 64,
`endif
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cols,
    output logic [3:0]  rows,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [15:0] dataout
);

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int             REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_N = REP_W'(REPEAT_SCANS);
    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_next;
`endif

    logic [3:0]  r_cols_m;
    logic [3:0]  r_cols_s;
    logic        w_tick;
    state_t      r_state;
    logic [1:0]  r_row_idx;
    logic [1:0]  r_col_idx;
    logic [3:0]  r_deb_cnt;
    logic [3:0]  r_rel_cnt;
    logic [3:0]  r_rows;
    logic        r_key_valid;
    logic [3:0]  r_key_code;
    logic        r_key_held;
    logic [15:0] r_dataout;

    logic [1:0]  w_next_row;
    logic [3:0]  w_next_rows;
    logic        w_single_low;
    logic [1:0]  w_low_idx;
    logic        w_match;
    logic        w_col_up;
    logic [3:0]  w_deb_next;
    logic [3:0]  w_rel_next;
    logic [3:0]  w_code;

    scan_tick_gen #(
        .SCAN_DIV_W(SCAN_DIV_W)
    ) u_tick (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_tick (w_tick)
    );

    // Two-flop synchronizer for the asynchronous column sense lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cols_m <= 4'b1111;
            r_cols_s <= 4'b1111;
        end else begin
            r_cols_m <= cols;
            r_cols_s <= r_cols_m;
        end
    end

    // Decode of the synchronized columns against the current scan position.
    always_comb begin
        w_next_row   = r_row_idx + 2'd1;
        w_next_rows  = row_drive(w_next_row);
        w_single_low = (count_lows(r_cols_s) == 3'd1);
        w_low_idx    = low_index(r_cols_s);
        w_match      = (r_cols_s == row_drive(r_col_idx));
        w_col_up     = r_cols_s[r_col_idx];
        w_deb_next   = r_deb_cnt + 4'd1;
        w_rel_next   = r_rel_cnt + 4'd1;
        w_code       = KEYMAP[r_row_idx][r_col_idx];
`ifdef KEYPAD_AUTOREPEAT_EN
        w_rep_next   = r_rep_cnt + REP_W'(1);
`endif
    end

    // Scan / debounce / held state machine with registered outputs.
    // The accept fires on the clk after the debounce count reaches its target,
    // so a single-scan debounce accepts right after the detecting tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SCAN;
            r_row_idx   <= '0;
            r_col_idx   <= '0;
            r_deb_cnt   <= '0;
            r_rel_cnt   <= '0;
            r_rows      <= ROWS_RESET;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_key_held  <= 1'b0;
            r_dataout   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt   <= '0;
`endif
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (w_tick) begin
                        if (w_single_low) begin
                            r_col_idx <= w_low_idx;
                            r_deb_cnt <= 4'd1;
                            r_state   <= DEBOUNCE;
                        end else begin
                            r_row_idx <= w_next_row;
                            r_rows    <= w_next_rows;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (r_deb_cnt == DEB_N) begin
                        r_key_valid <= 1'b1;
                        r_key_code  <= w_code;
                        r_dataout   <= {r_dataout[11:0], w_code};
                        r_key_held  <= 1'b1;
                        r_rel_cnt   <= '0;
                        r_state     <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        r_rep_cnt   <= '0;
`endif
                    end else if (w_tick) begin
                        if (w_match) begin
                            r_deb_cnt <= w_deb_next;
                        end else begin
                            r_state   <= SCAN;
                            r_row_idx <= w_next_row;
                            r_rows    <= w_next_rows;
                        end
                    end
                end
                HELD: begin
                    if (w_tick) begin
                        if (w_col_up) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            r_rep_cnt <= '0;
`endif
                            if (w_rel_next == DEB_N) begin
                                r_state    <= SCAN;
                                r_key_held <= 1'b0;
                                r_row_idx  <= w_next_row;
                                r_rows     <= w_next_rows;
                            end else begin
                                r_rel_cnt  <= w_rel_next;
                            end
                        end else begin
                            r_rel_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            if (w_rep_next == REP_N) begin
                                r_rep_cnt   <= '0;
                                r_key_valid <= 1'b1;
                                r_dataout   <= {r_dataout[11:0], r_key_code};
                            end else begin
                                r_rep_cnt   <= w_rep_next;
                            end
`endif
                        end
                    end
                end
                default: begin
                    r_state <= SCAN;
                end
            endcase
        end
    end

    assign rows      = r_rows;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_held  = r_key_held;
    assign dataout   = r_dataout;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed stimulus through a keypad matrix model, with a
// behavioural reference checked every cycle plus literal expectations.
module tb_keypad_scanner;

    localparam int DIV_W  = 2;
    localparam int DEB    = 2;
    localparam int PERIOD = 1 << DIV_W;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP      = 3;
    localparam int HOLD_CYC = 8;
`else
    localparam int HOLD_CYC = 40;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] dataout;

    logic        direct_en   = 1'b0;
    logic [3:0]  direct_cols = 4'hF;
    logic [15:0] pressed     = 16'h0;   // bit row*4+col

    int checks   = 0;
    int failures = 0;
    int n_pulses = 0;

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its column low while its row is driven low.
    function automatic logic [3:0] matrix(input logic [3:0] r, input logic [15:0] p);
        logic [3:0] c;
        c = 4'hF;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                if (!r[row] && p[row*4+col]) c[col] = 1'b0;
        return c;
    endfunction

    assign cols = direct_en ? direct_cols : matrix(rows, pressed);

    keypad_scanner #(
        .SCAN_DIV_W     (DIV_W),
`ifdef KEYPAD_AUTOREPEAT_EN
        .REPEAT_SCANS   (REP),
`endif
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cols      (cols),
        .rows      (rows),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .dataout   (dataout)
    );

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    logic [3:0] KEYS [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};
    int          m_mode;   // 0 scanning, 1 confirming, 2 holding
    int          m_row, m_col, m_cnt, m_rel, m_div;
`ifdef KEYPAD_AUTOREPEAT_EN
    int          m_rep;
`endif
    logic [3:0]  m_c1, m_cs, m_code;
    logic [15:0] m_data;
    logic        m_kv, m_held;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        int  nlow, lowpos;
        bit  tick;
        if (rst) begin
            m_mode = 0; m_row = 0; m_col = 0; m_cnt = 0; m_rel = 0; m_div = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
            m_rep = 0;
`endif
            m_c1 = 4'hF; m_cs = 4'hF; m_code = 4'h0; m_data = 16'h0;
            m_kv = 1'b0; m_held = 1'b0; m_live = 1'b1;
        end else begin
            tick = (m_div == PERIOD - 1);
            m_kv = 1'b0;
            nlow = 0; lowpos = 0;
            for (int i = 0; i < 4; i++)
                if (!m_cs[i]) begin nlow++; lowpos = i; end
            if (m_mode == 1 && m_cnt == DEB) begin
                m_kv = 1'b1;
                m_code = KEYS[m_row*4 + m_col];
                m_data = {m_data[11:0], m_code};
                m_mode = 2; m_held = 1'b1; m_rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
                m_rep = 0;
`endif
            end else if (tick) begin
                if (m_mode == 0) begin
                    if (nlow == 1) begin m_col = lowpos; m_cnt = 1; m_mode = 1; end
                    else m_row = (m_row + 1) % 4;
                end else if (m_mode == 1) begin
                    if (m_cs == (4'hF ^ (4'h1 << m_col))) m_cnt++;
                    else begin m_mode = 0; m_row = (m_row + 1) % 4; end
                end else begin
                    if (m_cs[m_col]) begin
                        m_rel++;
`ifdef KEYPAD_AUTOREPEAT_EN
                        m_rep = 0;
`endif
                        if (m_rel == DEB) begin
                            m_mode = 0; m_held = 1'b0; m_row = (m_row + 1) % 4;
                        end
                    end else begin
                        m_rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        m_rep++;
                        if (m_rep == REP) begin
                            m_rep = 0; m_kv = 1'b1; m_data = {m_data[11:0], m_code};
                        end
`endif
                    end
                end
            end
            m_div = (m_div + 1) % PERIOD;
            m_cs = m_c1;
            m_c1 = cols;
        end
    end

    // Per-cycle comparison of every output against the reference.
    always @(negedge clk) begin
        if (m_live) begin
            check("rows",      16'(rows),      16'(4'hF ^ (4'h1 << m_row)));
            check("key_valid", 16'(key_valid), 16'(m_kv));
            check("key_code",  16'(key_code),  16'(m_code));
            check("key_held",  16'(key_held),  16'(m_held));
            check("dataout",   dataout,        m_data);
        end
        if (key_valid === 1'b1) n_pulses++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_kv(input string name);
        int n = 0;
        while (key_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check(name, 16'(key_valid), 16'h1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (key_held !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        check(name, 16'(key_held), 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press_release(input int r, input int c, input logic [15:0] exp_data);
        pressed[r*4+c] = 1'b1;
        wait_kv("digit_pulse");
        repeat (8) @(negedge clk);
        pressed = 16'h0;
        wait_idle("digit_release");
        check("digit_dataout", dataout, exp_data);
    endtask

    initial begin
        logic [3:0] rot [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        int n;

        // Reset held for 3 clocks with no keys down.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rows",    16'(rows),      16'h000E);
        check("rst_dataout", dataout,        16'h0000);
        check("rst_valid",   16'(key_valid), 16'h0);
        check("rst_held",    16'(key_held),  16'h0);
        check("rst_code",    16'(key_code),  16'h0);
        rst = 1'b0;

        // Rows rotate once per tick.
        for (int k = 0; k < 4; k++) begin
            repeat (PERIOD) @(negedge clk);
            check("rotate", 16'(rows), 16'(rot[k]));
        end

        // Single press of row1 col2.
        n_pulses = 0;
        pressed[1*4+2] = 1'b1;
        wait_kv("single_pulse");
        check("single_code", 16'(key_code), 16'h0006);
        check("single_data", dataout,       16'h0006);
        repeat (HOLD_CYC) @(negedge clk);
        check("single_held", 16'(key_held), 16'h1);
        pressed = 16'h0;
        wait_idle("single_release");
        check("single_count", 16'(n_pulses), 16'h1);

        // Digit entry from a cleared register.
        do_reset();
        press_release(0, 0, 16'h0001);
        press_release(0, 1, 16'h0012);
        press_release(3, 1, 16'h0120);
        press_release(1, 3, 16'h120B);

        // Reset while confirming a press.
        direct_en = 1'b1;
        direct_cols = 4'b1101;
        n = 0;
        while (m_mode != 1 && n < 100) begin @(negedge clk); n++; end
        check("reach_debounce", 16'(m_mode), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rows",  16'(rows),      16'h000E);
        check("midrst_valid", 16'(key_valid), 16'h0);
        check("midrst_data",  dataout,        16'h0000);
        check("midrst_held",  16'(key_held),  16'h0);

        // Bounce: low one tick, high one tick, low one tick, then released.
        rst = 1'b0;
        n_pulses = 0;
        direct_cols = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            repeat (PERIOD) @(negedge clk);
            direct_cols = (k == 1) ? 4'b1110 : 4'b1111;
        end
        check("bounce_rows_a", 16'(rows), 16'h000B);
        repeat (PERIOD) @(negedge clk);
        check("bounce_rows_b", 16'(rows), 16'h0007);
        check("bounce_count",  16'(n_pulses), 16'h0);
        direct_en = 1'b0;

        // Ghosting: two columns low on one row is never accepted.
        pressed = 16'h0003;
        repeat (60) @(negedge clk);
        check("ghost_count", 16'(n_pulses), 16'h0);
        pressed = 16'h0;
        repeat (8) @(negedge clk);

        // Second key while held is ignored.
        pressed[2*4+0] = 1'b1;
        wait_kv("held_pulse");
        pressed[2*4+1] = 1'b1;
        pressed[3*4+3] = 1'b1;
        repeat (HOLD_CYC) @(negedge clk);
        check("held_count", 16'(n_pulses), 16'h1);
        check("held_code",  16'(key_code), 16'h0007);
        check("held_flag",  16'(key_held), 16'h1);
        pressed = 16'h0;
        wait_idle("held_release");
        check("held_data", dataout, 16'h0007);

`ifdef KEYPAD_AUTOREPEAT_EN
        // Auto-repeat: hold '5' for 10 ticks after accept.
        do_reset();
        n_pulses = 0;
        pressed[1*4+1] = 1'b1;
        wait_kv("rep_pulse");
        repeat (10 * PERIOD) @(negedge clk);
        pressed = 16'h0;
        wait_idle("rep_release");
        check("rep_count", 16'(n_pulses), 16'h4);
        check("rep_data",  dataout,       16'h5555);
`endif

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
